seven_segment_seconds: RTL and testbench
========================================

Name: seven_segment_seconds

Overview:
- Tiny Tapeout user block: a free-running decimal seconds counter that shows a single digit 0-9 on a common-cathode seven-segment display.
- A prescaler divides the system clock down to one "tick" per second, and the digit advances once per tick.
- `ui_in` can override the tick period at runtime.
- Top-level user module; wrapped by the TT harness.

Parameters:
- `MAX_COUNT`, default 10_000_000: clock cycles per tick when `ui_in` == 0. Legal range 2..2^24-1.

Ports:
- `clk`: input, 1. System clock; all state updates on the rising edge.
- `rst_n`: input, 1. Asynchronous active-low reset.
- `ena`: input, 1. Harness select. Unused; the design runs regardless of its value.
- `ui_in`: input, 8. Period override; 0 selects `MAX_COUNT`.
- `uo_out`: output, 8. [6:0] segments {g,f,e,d,c,b,a}, active high; [7] decimal point.
- `uio_in`: input, 8. Unused.
- `uio_out`: output, 8. [3:0] current digit (binary); [7:4] = 0.
- `uio_oe`: output, 8. Constant 8'h0F.

Behaviour:
- Clock and reset: one clock (`clk`). Reset (`rst_n`) is asynchronous and active-low.
- Reset (`rst_n` low, any time, including mid-count):
  - prescaler counter = 0, digit = 0.
  - `uo_out` = 8'h3F (shows "0", DP off); `uio_out` = 8'h00.
  - Outputs take these values immediately, without waiting for a clock edge.
- Compare value (combinational, re-evaluated every cycle):
  - `ui_in` == 0 → `compare` = `MAX_COUNT` (24-bit).
  - otherwise → `compare` = {`ui_in`, 10'b0}, i.e. `ui_in` × 1024.
- Prescaler (24-bit counter `cnt`), each clock edge:
  - if `cnt` >= `compare`−1: `cnt` ← 0 and assert a one-cycle internal tick.
  - else: `cnt` ← `cnt`+1.
  - The `>=` test guarantees wrap on the next edge if `compare` is lowered below the current count.
  - Tick period = `compare` cycles.
- Digit (4-bit), on tick: 9 → 0, else +1. No other update path.
- First tick after reset release occurs on the `compare`-th rising edge. The digit changes on that edge; outputs reflect it from that edge onward (registered digit, combinational decode).
- Decoder, digit → `uo_out`[6:0]:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - Values 10-15 are unreachable; they decode to 00 (blank) for safety.
- `uo_out`[7] = 0 unless `DP_BLINK_EN` is defined.
- `uio_out`[3:0] = digit; `uio_out`[7:4] = 0; `uio_oe` = 8'h0F constant, including during reset.
- `ena` and `uio_in` have no effect.

Optional Feature:
- Macro: `DP_BLINK_EN`.
- Defined: `uo_out`[7] = 1 while `cnt` < `compare`/2 (integer shift-right by 1), else 0. This gives a ~50% DP blink, in phase with each digit change.
  - `uo_out`[7] = 1 immediately after reset, since `cnt` = 0.
- Undefined: `uo_out`[7] is tied to 0 and no comparison logic is built.

Test Plan (instantiate with `MAX_COUNT`=1000, `ui_in`=0, clock 10 ns):
- Reset: hold `rst_n`=0 for 10 cycles → `uo_out`=8'h3F, `uio_out`=8'h00, `uio_oe`=8'h0F.
  - Drop `rst_n` mid-count (asynchronously) → outputs return to 3F / 00 without waiting for a clock edge.
- Release reset, run 999 edges → `segments`=3F. On edge 1000 → `segments`=06 and `uio_out`[3:0]=1.
- Run 10 ticks (10,000 cycles) → `segments` sequence 06,5B,4F,66,6D,7D,07,7F,6F,3F; the digit wraps 9→0.
- Set `ui_in`=8'h01 after reset → tick every 1024 cycles; `segments`=06 after exactly 1024 edges.
- Shorten the period mid-count: run 900 cycles with `ui_in`=0, then set `ui_in`=0 stays but apply `MAX_COUNT`-independent override `ui_in`=... (use a 2nd instance with `MAX_COUNT`=2000: at `cnt`=1500 set `ui_in`=1) → wrap and digit increment on the very next edge.
- Toggle `ena` and `uio_in` randomly throughout → outputs identical to an undisturbed run.
- With `DP_BLINK_EN` defined: `uo_out`[7]=1 for cycles 0-499 of each tick and 0 for cycles 500-999.

Source files
------------

// File: rtl/seven_segment_seconds.sv
// Free-running decimal seconds counter driving one common-cathode seven-segment digit.
// Optional macro DP_BLINK_EN: blink the decimal point for the first half of every tick period.
module seven_segment_seconds #(
    parameter int unsigned MAX_COUNT = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [23:0] MaxCount24 = 24'(MAX_COUNT);

    logic [23:0] compare;
    logic [23:0] cnt_q;
    logic [23:0] cnt_d;
    logic [3:0]  digit_q;
    logic [3:0]  digit_d;
    logic        tick;
    logic [6:0]  segments;
    logic        dp;
    logic        unused_inputs;

    assign unused_inputs = &{ena, uio_in, 1'b0};

    // A zero override falls back to the build-time period; otherwise ui_in counts in 1024-cycle steps.
    always_comb begin
        compare = MaxCount24;
        if (ui_in != 8'd0) begin
            compare = {6'd0, ui_in, 10'd0};
        end
    end

    // The >= test makes a freshly shortened period wrap on the very next edge.
    always_comb begin
        tick    = (cnt_q >= (compare - 24'd1));
        cnt_d   = cnt_q + 24'd1;
        digit_d = digit_q;
        if (tick) begin
            cnt_d   = 24'd0;
            digit_d = (digit_q == 4'd9) ? 4'd0 : (digit_q + 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 24'd0;
            digit_q <= 4'd0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
        end
    end

    always_comb begin
        segments = 7'h00;
        case (digit_q)
            4'd0:    segments = 7'h3F;
            4'd1:    segments = 7'h06;
            4'd2:    segments = 7'h5B;
            4'd3:    segments = 7'h4F;
            4'd4:    segments = 7'h66;
            4'd5:    segments = 7'h6D;
            4'd6:    segments = 7'h7D;
            4'd7:    segments = 7'h07;
            4'd8:    segments = 7'h7F;
            4'd9:    segments = 7'h6F;
            default: segments = 7'h00;
        endcase
    end

`ifdef DP_BLINK_EN
    assign dp = (cnt_q < (compare >> 1));
`else
    assign dp = 1'b0;
`endif

    assign uo_out  = {dp, segments};
    assign uio_out = {4'd0, digit_q};
    assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_seven_segment_seconds.sv
// Scoreboard bench for seven_segment_seconds: two instances (periods 1000 and 2000) against an elapsed-time model.
module tb_seven_segment_seconds;

    localparam int MAXC_A = 1000;
    localparam int MAXC_B = 2000;
    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] uio_in;
    logic [7:0] ui_a, ui_b;
    logic [7:0] uo_a, uio_a, oe_a;
    logic [7:0] uo_b, uio_b, oe_b;

    seven_segment_seconds #(.MAX_COUNT(MAXC_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_a), .uo_out(uo_a),
        .uio_in(uio_in), .uio_out(uio_a), .uio_oe(oe_a)
    );

    seven_segment_seconds #(.MAX_COUNT(MAXC_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_b), .uo_out(uo_b),
        .uio_in(uio_in), .uio_out(uio_b), .uio_oe(oe_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] uo_a;
        logic [7:0] uio_a;
        logic [7:0] uo_b;
        logic [7:0] uio_b;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   cyc_n  = 0;

    // Reference model: cycles elapsed since the last completed tick and number of ticks seen.
    int elapsed_m [2];
    int ticks_m   [2];

    function automatic int period(input int idx, input logic [7:0] ui);
        if (ui == 8'd0) return (idx == 0) ? MAXC_A : MAXC_B;
        return int'(ui) * 1024;
    endfunction

    function automatic logic [7:0] exp_uo(input int idx, input logic [7:0] ui);
        logic dp;
        dp = 1'b0;
`ifdef DP_BLINK_EN
        dp = (elapsed_m[idx] < period(idx, ui) / 2);
`endif
        return {dp, SEG_TAB[ticks_m[idx] % 10]};
    endfunction

    function automatic logic [7:0] exp_uio(input int idx);
        return 8'(ticks_m[idx] % 10);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            elapsed_m[k] = 0;
            ticks_m[k]   = 0;
        end
    endtask

    // One clock edge: a full period of elapsed time completes a tick.
    task automatic model_edge(input int idx, input logic [7:0] ui);
        if (elapsed_m[idx] + 1 >= period(idx, ui)) begin
            ticks_m[idx]   = ticks_m[idx] + 1;
            elapsed_m[idx] = 0;
        end else begin
            elapsed_m[idx] = elapsed_m[idx] + 1;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.cyc   = cyc_n;
        e.uo_a  = exp_uo(0, ui_a);
        e.uio_a = exp_uio(0);
        e.uo_b  = exp_uo(1, ui_b);
        e.uio_b = exp_uio(1);
        sb.push_back(e);
    endtask

    task automatic cycle(input logic [7:0] na, input logic [7:0] nb);
        @(posedge clk);
        #1;
        cyc_n++;
        if (rst_n) begin
            model_edge(0, ui_a);
            model_edge(1, ui_b);
        end
        ui_a   = na;
        ui_b   = nb;
        ena    = 1'($urandom);
        uio_in = 8'($urandom);
        push_exp();
    endtask

    // Reset dropped between clock edges; the monitor samples 1 ns later, well before any edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        push_exp();
        repeat (3) cycle(ui_a, ui_b);
        rst_n = 1'b1;
    endtask

    task automatic check(input string name, input int cyc, input logic [7:0] uo, input logic [7:0] uio,
                         input logic [7:0] oe, input logic [7:0] e_uo, input logic [7:0] e_uio);
        total++;
        if (uo === e_uo && uio === e_uio && oe === 8'h0F) begin
            passed++;
        end else begin
            $display("FAIL %s cycle %0d: uo_out=%02h uio_out=%02h uio_oe=%02h, expected uo_out=%02h uio_out=%02h uio_oe=0f",
                     name, cyc, uo, uio, oe, e_uo, e_uio);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("inst_a", e.cyc, uo_a, uio_a, oe_a, e.uo_a, e.uio_a);
                check("inst_b", e.cyc, uo_b, uio_b, oe_b, e.uo_b, e.uio_b);
            end
        end
    end

    initial begin
        logic [7:0] na, nb;
        rst_n  = 1'b0;
        ena    = 1'b0;
        uio_in = 8'h00;
        ui_a   = 8'h00;
        ui_b   = 8'h00;
        model_reset();
        repeat (10) cycle(8'h00, 8'h00);
        rst_n = 1'b1;

        // Default periods; instance b has its period cut to 1024 once it is past 1500.
        for (int i = 0; i < 11200; i++) begin
            nb = (ui_b == 8'h00 && elapsed_m[1] == 1500) ? 8'h01 : ui_b;
            cycle(8'h00, nb);
        end

        async_reset();

        // Override of 1 on instance a, random small overrides on instance b.
        for (int i = 0; i < 2100; i++) begin
            nb = (i % 500 == 0) ? 8'($urandom_range(1, 4)) : ui_b;
            cycle(8'h01, nb);
        end

        // Random period changes on both, with one asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            na = (i % 300 == 0) ? 8'($urandom_range(0, 3)) : ui_a;
            nb = (i % 350 == 0) ? 8'($urandom_range(0, 2)) : ui_b;
            if (i == 1777) async_reset();
            cycle(na, nb);
        end

        @(negedge clk);
        #3;
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expectations left in scoreboard, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
